// File: rtl/risc16_dbus_pkg.sv
// Shared constants and types for the risc16f data-bus responder: MMIO page,
// register offsets and the timer control register layout.
package risc16_dbus_pkg;

  localparam int unsigned DW = 16;

  localparam logic [7:0] MMIO_PAGE = 8'hFF;

  localparam logic [7:0] GPIO_OUT_OFS = 8'h00;
  localparam logic [7:0] GPIO_IN_OFS  = 8'h02;
  localparam logic [7:0] COUNT_OFS    = 8'h04;
  localparam logic [7:0] COMPARE_OFS  = 8'h06;
  localparam logic [7:0] STATUS_OFS   = 8'h08;
  localparam logic [7:0] CTRL_OFS     = 8'h0A;

  localparam int unsigned STATUS_MATCH_BIT = 0;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;
  localparam int unsigned CTRL_IE_BIT  = 2;
  localparam int unsigned CTRL_W       = 3;

  typedef struct packed {
    logic ie;
    logic clr_on_match;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/risc16_timer.sv
// Compare timer: prescaler, COUNT/COMPARE, sticky MATCH flag and registered irq.
module risc16_timer
  import risc16_dbus_pkg::*;
#(
  parameter int unsigned PRESCALE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     wdata,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic              status_we,
  input  logic              ctrl_we,
  output logic [DW-1:0]     count,
  output logic [DW-1:0]     compare,
  output logic              match,
  output logic [CTRL_W-1:0] ctrl,
  output logic              irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  ctrl_t         ctrl_q;
  logic [PW-1:0] presc;
  logic          tick;
  logic [DW-1:0] count_inc;
  logic          hit;

  assign ctrl      = ctrl_q;
  assign tick      = ctrl_q.en && (presc == PRESC_LAST);
  assign count_inc = count + DW'(1);
  // A CPU load of COUNT pre-empts the tick, so no match is evaluated then.
  assign hit       = tick && !count_we && (count_inc == compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!ctrl_q.en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count_we) begin
      count <= wdata;
    end else if (tick) begin
      count <= (hit && ctrl_q.clr_on_match) ? '0 : count_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare <= '1;
      ctrl_q  <= '0;
    end else begin
      if (compare_we) compare <= wdata;
      if (ctrl_we) begin
        ctrl_q.en           <= wdata[CTRL_EN_BIT];
        ctrl_q.clr_on_match <= wdata[CTRL_CLR_BIT];
        ctrl_q.ie           <= wdata[CTRL_IE_BIT];
      end
    end
  end

  // Set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (hit) begin
        match <= 1'b1;
      end else if (status_we && wdata[STATUS_MATCH_BIT]) begin
        match <= 1'b0;
      end
      irq <= match && ctrl_q.ie;
    end
  end

endmodule

// File: rtl/risc16_dbus_responder.sv
// Data-bus responder for risc16f: word RAM with combinational read plus an MMIO
// page (GPIO, compare timer).
module risc16_dbus_responder
  import risc16_dbus_pkg::*;
#(
  parameter int unsigned RAM_AW    = 10,
  parameter int unsigned PRESCALE  = 16,
  parameter string       INIT_FILE = "dmem.hex"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   daddr,
  input  logic [15:0]   ddout,
  input  logic          doe,
  input  logic          dwe,
  output logic [15:0]   ddin,
  input  logic [15:0]   gpio_in,
  output logic [15:0]   gpio_out,
  output logic          irq
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
  localparam string unused_init_file = INIT_FILE;

  logic [DW-1:0]     mem [RAM_DEPTH];
  logic [RAM_AW-1:0] idx;
  logic              mmio;
  logic [7:0]        ofs;
  logic              mmio_we;
  logic [DW-1:0]     gpio_meta;
  logic [DW-1:0]     gpio_sync;
  logic [DW-1:0]     count;
  logic [DW-1:0]     compare;
  logic              match;
  logic [CTRL_W-1:0] ctrl;
  logic              unused_a0;

  assign unused_a0 = daddr[0];
  assign mmio      = (daddr[15:8] == MMIO_PAGE);
  assign idx       = daddr[RAM_AW:1];
  assign ofs       = {daddr[7:1], 1'b0};
  assign mmio_we   = dwe && mmio;

  // RAM is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (dwe && !mmio && !rst) begin
      mem[idx] <= ddout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out  <= '0;
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      if (mmio_we && (ofs == GPIO_OUT_OFS)) gpio_out <= ddout;
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
    end
  end

  risc16_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .wdata      (ddout),
    .count_we   (mmio_we && (ofs == COUNT_OFS)),
    .compare_we (mmio_we && (ofs == COMPARE_OFS)),
    .status_we  (mmio_we && (ofs == STATUS_OFS)),
    .ctrl_we    (mmio_we && (ofs == CTRL_OFS)),
    .count      (count),
    .compare    (compare),
    .match      (match),
    .ctrl       (ctrl),
    .irq        (irq)
  );

  // Combinational read: the core samples ddin in the same cycle it raises doe.
  always_comb begin
    ddin = '0;
    if (doe) begin
      if (mmio) begin
        unique case (ofs)
          GPIO_OUT_OFS: ddin = gpio_out;
          GPIO_IN_OFS:  ddin = gpio_sync;
          COUNT_OFS:    ddin = count;
          COMPARE_OFS:  ddin = compare;
          STATUS_OFS:   ddin = DW'(match);
          CTRL_OFS:     ddin = DW'(ctrl);
          default:      ddin = '0;
        endcase
      end else begin
        ddin = mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_risc16_dbus_responder.sv
// Directed self-checking bench for risc16_dbus_responder (PRESCALE=4).
module tb_risc16_dbus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] daddr, ddout, ddin, gpio_in, gpio_out;
  logic        doe, dwe, irq;

  int checks = 0;
  int errors = 0;
  logic [15:0] v;

  risc16_dbus_responder #(.RAM_AW(10), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .daddr(daddr), .ddout(ddout), .doe(doe), .dwe(dwe),
    .ddin(ddin), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Drive a write that commits on the next posedge; returns just after the following negedge.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    daddr = a; ddout = d; dwe = 1'b1; doe = 1'b0;
    @(negedge clk);
    dwe = 1'b0;
  endtask

  // Combinational read sampled away from any clock edge.
  task automatic rd(input logic [15:0] a, output logic [15:0] val);
    daddr = a; doe = 1'b1;
    #1 val = ddin;
    doe = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; doe = 1'b0; dwe = 1'b0; daddr = '0; ddout = '0; gpio_in = '0;
    step(2);
    checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL reset_gpio_out got=%h exp=0000", gpio_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd(16'hFF06, v);
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_compare got=%h exp=FFFF", v); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_ram;
    wr(16'h0010, 16'hBEEF);
    rd(16'h0010, v);
    checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL ram_rd got=%h exp=BEEF", v); end
    rd(16'h0011, v);
    checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL ram_rd_odd got=%h exp=BEEF", v); end
    daddr = 16'h0010; doe = 1'b0;
    #1 checks++; if (ddin !== 16'h0000) begin errors++; $display("FAIL ram_doe0 got=%h exp=0000", ddin); end
    wr(16'h0020, 16'h1111);
    // Illegal doe+dwe: pre-write data visible, write still performed.
    daddr = 16'h0020; ddout = 16'h2222; doe = 1'b1; dwe = 1'b1;
    #1 checks++; if (ddin !== 16'h1111) begin errors++; $display("FAIL ram_rw_old got=%h exp=1111", ddin); end
    @(negedge clk); dwe = 1'b0;
    #1 checks++; if (ddin !== 16'h2222) begin errors++; $display("FAIL ram_rw_new got=%h exp=2222", ddin); end
    doe = 1'b0;
    wr(16'h0820, 16'h3333);
    rd(16'h0020, v);
    checks++; if (v !== 16'h3333) begin errors++; $display("FAIL ram_alias got=%h exp=3333", v); end
  endtask

  task automatic test_gpio;
    wr(16'hFF00, 16'h00A5);
    checks++; if (gpio_out !== 16'h00A5) begin errors++; $display("FAIL gpio_out got=%h exp=00A5", gpio_out); end
    rd(16'hFF00, v);
    checks++; if (v !== 16'h00A5) begin errors++; $display("FAIL gpio_out_rd got=%h exp=00A5", v); end
    step(1);
    gpio_in = 16'h1234;
    rd(16'hFF02, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL gpio_in_c1 got=%h exp=0000", v); end
    step(1);
    rd(16'hFF02, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL gpio_in_c2 got=%h exp=0000", v); end
    step(1);
    rd(16'hFF02, v);
    checks++; if (v !== 16'h1234) begin errors++; $display("FAIL gpio_in_c3 got=%h exp=1234", v); end
    wr(16'hFF02, 16'hFFFF);
    rd(16'hFF02, v);
    checks++; if (v !== 16'h1234) begin errors++; $display("FAIL gpio_in_ro got=%h exp=1234", v); end
    rd(16'hFF0C, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mmio_unmapped got=%h exp=0000", v); end
  endtask

  task automatic test_timer_match;
    wr(16'hFF06, 16'h0003);
    wr(16'hFF0A, 16'h0005);
    rd(16'hFF0A, v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL ctrl_rd got=%h exp=0005", v); end
    step(11);
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL tm_count11 got=%h exp=0002", v); end
    rd(16'hFF08, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL tm_status11 got=%h exp=0000", v); end
    step(1);
    rd(16'hFF08, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL tm_status12 got=%h exp=0001", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tm_irq12 got=%b exp=0", irq); end
    step(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tm_irq13 got=%b exp=1", irq); end
    wr(16'hFF08, 16'h0001);
    rd(16'hFF08, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL tm_w1c got=%h exp=0000", v); end
    step(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tm_irq_clr got=%b exp=0", irq); end
  endtask

  task automatic test_clr_on_match;
    wr(16'hFF0A, 16'h0000);
    wr(16'hFF04, 16'h0000);
    wr(16'hFF06, 16'h0002);
    wr(16'hFF08, 16'h0001);
    wr(16'hFF0A, 16'h0003);
    step(4);
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL com_count_a got=%h exp=0001", v); end
    step(4);
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL com_count_b got=%h exp=0000", v); end
    rd(16'hFF08, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL com_match_b got=%h exp=0001", v); end
    wr(16'hFF08, 16'h0001);
    step(3);
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL com_count_c got=%h exp=0001", v); end
    rd(16'hFF08, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL com_match_c got=%h exp=0000", v); end
    step(4);
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL com_count_d got=%h exp=0000", v); end
    rd(16'hFF08, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL com_match_d got=%h exp=0001", v); end
  endtask

  task automatic test_wrap_and_load;
    wr(16'hFF0A, 16'h0000);
    wr(16'hFF06, 16'h0001);
    wr(16'hFF04, 16'hFFFF);
    wr(16'hFF08, 16'h0001);
    wr(16'hFF0A, 16'h0001);
    step(4);
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL wrap_count got=%h exp=0000", v); end
    step(3);
    wr(16'hFF04, 16'h0007);
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0007) begin errors++; $display("FAIL load_in_tick got=%h exp=0007", v); end
    rd(16'hFF08, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL load_no_match got=%h exp=0000", v); end
    step(4);
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0008) begin errors++; $display("FAIL load_next_tick got=%h exp=0008", v); end
  endtask

  task automatic test_mid_reset;
    wr(16'hFF0A, 16'h0000);
    wr(16'hFF06, 16'h0001);
    wr(16'hFF04, 16'h0000);
    wr(16'hFF08, 16'h0001);
    wr(16'hFF0A, 16'h0005);
    step(6);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mr_irq_pre got=%b exp=1", irq); end
    rst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mr_irq got=%b exp=0", irq); end
    checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL mr_gpio_out got=%h exp=0000", gpio_out); end
    rd(16'hFF04, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mr_count got=%h exp=0000", v); end
    rd(16'hFF06, v);
    checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL mr_compare got=%h exp=FFFF", v); end
    rd(16'hFF08, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mr_status got=%h exp=0000", v); end
    rd(16'hFF0A, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mr_ctrl got=%h exp=0000", v); end
    wr(16'h0010, 16'h0000);
    rst = 1'b0;
    step(1);
    rd(16'h0010, v);
    checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL mr_ram_kept got=%h exp=BEEF", v); end
  endtask

  initial begin
    test_reset;
    test_ram;
    test_gpio;
    test_timer_match;
    test_clr_on_match;
    test_wrap_and_load;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
